// File: rtl/ssd_scan_if.sv
// Load/status and display-drive bundle for the seven-segment scan driver.
// The master issues loads; the slave (the driver) returns busy and the anode/segment drives.
interface ssd_scan_if #(
  parameter int DIGITS = 4,
  parameter int VAL_W  = 13
);
  logic [VAL_W-1:0]  value;
  logic              load;
  logic              busy;
  logic [DIGITS-1:0] anode;
  logic [6:0]        seg;

  modport master (output value, load, input busy, anode, seg);
  modport slave  (input value, load, output busy, anode, seg);
endinterface

// File: rtl/ssd_scan_driver.sv
// Binary-to-BCD (shift-add-3) converter feeding a double-buffered, time-multiplexed
// common-anode seven-segment scan. Define SSD_BLANK_EN to blank leading-zero digits.
module ssd_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int VAL_W        = 13,
  parameter int REFRESH_BITS = 18
) (
  input  logic      clk,
  input  logic      rst,
  ssd_scan_if.slave bus
);
  localparam int NIB   = DIGITS + 1;
  localparam int BCD_W = 4 * NIB;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VAL_W - 1);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state_reg,  state_next;
  logic [VAL_W-1:0]    shift_reg,  shift_next;
  logic [BCD_W-1:0]    bcd_reg,    bcd_next;
  logic                sticky_reg, sticky_next;
  logic [CNT_W-1:0]    iter_reg,   iter_next;
  logic [4*DIGITS-1:0] disp_reg,   disp_next;
  logic                ovf_reg,    ovf_next;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shifted;

  genvar gi;

  // Add-3 correction of every nibble before the shift.
  for (gi = 0; gi < NIB; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                              : bcd_reg[4*gi +: 4];
  end
  assign bcd_shifted = {bcd_adj[BCD_W-2:0], shift_reg[VAL_W-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      bcd_reg    <= '0;
      sticky_reg <= 1'b0;
      iter_reg   <= '0;
      disp_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shift_reg  <= shift_next;
      bcd_reg    <= bcd_next;
      sticky_reg <= sticky_next;
      iter_reg   <= iter_next;
      disp_reg   <= disp_next;
      ovf_reg    <= ovf_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shift_next  = shift_reg;
    bcd_next    = bcd_reg;
    sticky_next = sticky_reg;
    iter_next   = iter_reg;
    disp_next   = disp_reg;
    ovf_next    = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          shift_next  = bus.value;
          bcd_next    = '0;
          sticky_next = 1'b0;
          iter_next   = '0;
          state_next  = CONV;
        end
      end
      CONV: begin
        shift_next  = shift_reg << 1;
        bcd_next    = bcd_shifted;
        // A bit pushed out of the top nibble means the value could not fit at all.
        sticky_next = sticky_reg | bcd_adj[BCD_W-1];
        iter_next   = iter_reg + 1'b1;
        if (iter_reg == LAST_ITER) begin
          disp_next  = bcd_shifted[4*DIGITS-1:0];
          ovf_next   = sticky_reg | bcd_adj[BCD_W-1] | (bcd_shifted[BCD_W-1 -: 4] != 4'd0);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = (state_reg == CONV);

  logic [REFRESH_BITS-1:0] refresh_reg;
  logic [DIG_W-1:0]        digit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_reg <= '0;
      digit_reg   <= '0;
    end else begin
      refresh_reg <= refresh_reg + 1'b1;
      if (&refresh_reg) begin
        digit_reg <= (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
      end
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  logic blank;

`ifdef SSD_BLANK_EN
  logic [DIGITS-1:0] zero_from;
  logic              zero_run;

  // zero_from[i]: digit i and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_reg[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end
  assign blank = zero_from[digit_reg] && (digit_reg != '0) && !ovf_reg;
`else
  assign blank = 1'b0;
`endif

  logic [DIGITS-1:0] anode_reg, anode_next;
  logic [6:0]        seg_reg,   seg_next;

  always_comb begin
    anode_next = ~(DIGITS'(1) << digit_reg);
    seg_next   = seg_decode(disp_reg[4*digit_reg +: 4]);
    if (ovf_reg) begin
      seg_next = 7'b1111110;
    end else if (blank) begin
      anode_next = '1;
      seg_next   = 7'b1111111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_reg <= '1;
      seg_reg   <= 7'b1111111;
    end else begin
      anode_reg <= anode_next;
      seg_reg   <= seg_next;
    end
  end

  assign bus.anode = anode_reg;
  assign bus.seg   = seg_reg;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: a 13-bit and a 14-bit instance share clock, reset and load
// stream; slot contents are checked against a table and a decimal-arithmetic model.
module tb_ssd_scan_driver;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111,
                         S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110, SB = 7'b1111111;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111, AOFF = 4'b1111;
`ifdef SSD_BLANK_EN
  localparam logic [6:0] LZS = SB;
  localparam logic [3:0] LZ1 = AOFF, LZ2 = AOFF, LZ3 = AOFF;
`else
  localparam logic [6:0] LZS = S0;
  localparam logic [3:0] LZ1 = A1, LZ2 = A2, LZ3 = A3;
`endif

  typedef struct {
    int unsigned     value;
    bit              wide_only;
    logic [3:0][6:0] seg;
    logic [3:0][3:0] an;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssd_scan_if #(.DIGITS(4), .VAL_W(13)) bus13 ();
  ssd_scan_if #(.DIGITS(4), .VAL_W(14)) bus14 ();

  ssd_scan_driver #(.DIGITS(4), .VAL_W(13), .REFRESH_BITS(2)) dut13 (.clk(clk), .rst(rst), .bus(bus13));
  ssd_scan_driver #(.DIGITS(4), .VAL_W(14), .REFRESH_BITS(2)) dut14 (.clk(clk), .rst(rst), .bus(bus14));

  // Edges since reset release; outputs after edge n show slot ((n-1)/4) mod 4.
  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return S0; 1: return S1; 2: return S2; 3: return S3; 4: return S4;
      5: return S5; 6: return S6; 7: return S7; 8: return S8; default: return S9;
    endcase
  endfunction

  // Decimal view of the value: digit k is (v / 10^k) mod 10; >= 10^4 is overflow.
  function automatic void model(input int unsigned v, output logic [3:0][6:0] es,
                                output logic [3:0][3:0] ea);
    int unsigned p;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      ea[k] = ~(4'b0001 << k);
      es[k] = (v >= 10000) ? SD : seg_of(int'((v / p) % 10));
`ifdef SSD_BLANK_EN
      if (v < 10000 && k > 0 && v < p) begin
        ea[k] = AOFF;
        es[k] = SB;
      end
`endif
      p = p * 10;
    end
  endfunction

  task automatic wait_slot(input int k);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(edge_n >= 1 && (((edge_n - 1) >> 2) % 4) == k && ((edge_n - 1) % 4) == 1)) begin
      @(negedge clk);
      guard++;
      if (guard > 64) begin
        check($sformatf("slot %0d wait timeout", k), 32'(guard), 32'(0));
        break;
      end
    end
  endtask

  task automatic check_slots(input string nm,
                             input logic [3:0][6:0] es13, input logic [3:0][3:0] ea13,
                             input logic [3:0][6:0] es14, input logic [3:0][3:0] ea14);
    for (int k = 0; k < 4; k++) begin
      wait_slot(k);
      check($sformatf("%s an13 slot%0d", nm, k), 32'(bus13.anode), 32'(ea13[k]));
      check($sformatf("%s seg13 slot%0d", nm, k), 32'(bus13.seg), 32'(es13[k]));
      check($sformatf("%s an14 slot%0d", nm, k), 32'(bus14.anode), 32'(ea14[k]));
      check($sformatf("%s seg14 slot%0d", nm, k), 32'(bus14.seg), 32'(es14[k]));
    end
  endtask

  task automatic drive(input int unsigned v, input logic ld);
    bus13.value = 13'(v);
    bus14.value = 14'(v);
    bus13.load  = ld;
    bus14.load  = ld;
  endtask

  // Load v; optionally pulse a second load v2 at cycle at2 after acceptance.
  task automatic run_load(input int unsigned v, input int unsigned v2, input int at2,
                          output int b13, output int b14);
    drive(v, 1'b1);
    @(negedge clk);
    drive(v, 1'b0);
    b13 = 0;
    b14 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus13.busy) b13++;
      if (bus14.busy) b14++;
      if (c == at2) drive(v2, 1'b1);
      else          drive(v, 1'b0);
      if (!bus13.busy && !bus14.busy && c != at2) break;
      @(negedge clk);
    end
    drive(v, 1'b0);
  endtask

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    while ((bus13.busy || bus14.busy) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({nm, " idle timeout"}, 32'(bus13.busy | bus14.busy), 32'(0));
  endtask

  vec_t            tbl [9];
  logic [3:0][6:0] es13, es14;
  logic [3:0][3:0] ea13, ea14;
  int              b13, b14;
  int unsigned     rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1234,  1'b0, {S1, S2, S3, S4},     {A3, A2, A1, A0}};
    tbl[1] = '{0,     1'b0, {LZS, LZS, LZS, S0},  {LZ3, LZ2, LZ1, A0}};
    tbl[2] = '{7,     1'b0, {LZS, LZS, LZS, S7},  {LZ3, LZ2, LZ1, A0}};
    tbl[3] = '{42,    1'b0, {LZS, LZS, S4, S2},   {LZ3, LZ2, A1, A0}};
    tbl[4] = '{8191,  1'b0, {S8, S1, S9, S1},     {A3, A2, A1, A0}};
    tbl[5] = '{1005,  1'b0, {S1, S0, S0, S5},     {A3, A2, A1, A0}};
    tbl[6] = '{9999,  1'b1, {S9, S9, S9, S9},     {A3, A2, A1, A0}};
    tbl[7] = '{16383, 1'b1, {SD, SD, SD, SD},     {A3, A2, A1, A0}};
    tbl[8] = '{10000, 1'b1, {SD, SD, SD, SD},     {A3, A2, A1, A0}};

    rst = 1'b1;
    drive(0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset busy13", 32'(bus13.busy), 32'(0));
    check("reset busy14", 32'(bus14.busy), 32'(0));
    check("reset anode13", 32'(bus13.anode), 32'(AOFF));
    check("reset seg13", 32'(bus13.seg), 32'(SB));
    check("reset anode14", 32'(bus14.anode), 32'(AOFF));
    check("reset seg14", 32'(bus14.seg), 32'(SB));

    rst = 1'b0;
    #1;
    check("pre-edge anode13", 32'(bus13.anode), 32'(AOFF));
    @(negedge clk);
    check("first edge anode13", 32'(bus13.anode), 32'(A0));
    check("first edge seg13", 32'(bus13.seg), 32'(S0));
    check("first edge anode14", 32'(bus14.anode), 32'(A0));
    repeat (3) @(negedge clk);
    check("edge4 anode13", 32'(bus13.anode), 32'(A0));
    @(negedge clk);
    check("edge5 anode13", 32'(bus13.anode), 32'(LZ1));
    model(0, es13, ea13);
    check_slots("after reset", es13, ea13, es13, ea13);

    // Table vectors: fixed expectations for both widths (13-bit side uses the model on wide values).
    for (int i = 0; i < 9; i++) begin
      run_load(tbl[i].value, 0, 0, b13, b14);
      check($sformatf("tbl%0d busy13 cycles", i), 32'(b13), 32'(13));
      check($sformatf("tbl%0d busy14 cycles", i), 32'(b14), 32'(14));
      if (tbl[i].wide_only) model(tbl[i].value & 32'h1FFF, es13, ea13);
      else begin
        es13 = tbl[i].seg;
        ea13 = tbl[i].an;
      end
      check_slots($sformatf("tbl%0d v=%0d", i, tbl[i].value), es13, ea13, tbl[i].seg, tbl[i].an);
    end

    // Second load three cycles into a conversion is dropped.
    run_load(42, 77, 3, b13, b14);
    check("busy-load busy13 cycles", 32'(b13), 32'(13));
    check("busy-load busy14 cycles", 32'(b14), 32'(14));
    model(42, es13, ea13);
    check_slots("busy-load", es13, ea13, es13, ea13);

    // Load held across the completion edge: dropped there, accepted on the following edge.
    drive(321, 1'b1);
    @(negedge clk);
    drive(321, 1'b0);
    repeat (12) @(negedge clk);
    check("completion: busy13 last cycle", 32'(bus13.busy), 32'(1));
    drive(654, 1'b1);
    @(negedge clk);
    check("completion: load dropped busy13", 32'(bus13.busy), 32'(0));
    check("completion: busy14 still", 32'(bus14.busy), 32'(1));
    @(negedge clk);
    drive(654, 1'b0);
    check("earliest reload busy13", 32'(bus13.busy), 32'(1));
    check("completion: load dropped busy14", 32'(bus14.busy), 32'(0));
    wait_idle("completion");
    model(654, es13, ea13);
    model(321, es14, ea14);
    check_slots("completion", es13, ea13, es14, ea14);

    // Random values, biased toward small ones so blanking gets exercised.
    for (int i = 0; i < 12; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 16383);
      run_load(rv, 0, 0, b13, b14);
      check($sformatf("rnd%0d busy13 cycles", i), 32'(b13), 32'(13));
      check($sformatf("rnd%0d busy14 cycles", i), 32'(b14), 32'(14));
      model(rv & 32'h1FFF, es13, ea13);
      model(rv, es14, ea14);
      check_slots($sformatf("rnd%0d v=%0d", i, rv), es13, ea13, es14, ea14);
    end

    // Reset in the middle of a conversion.
    drive(5678, 1'b1);
    @(negedge clk);
    drive(5678, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst busy13 before", 32'(bus13.busy), 32'(1));
    rst = 1'b1;
    #1;
    check("midrst busy13", 32'(bus13.busy), 32'(0));
    check("midrst busy14", 32'(bus14.busy), 32'(0));
    check("midrst anode13", 32'(bus13.anode), 32'(AOFF));
    check("midrst seg14", 32'(bus14.seg), 32'(SB));
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    model(0, es13, ea13);
    check_slots("midrst", es13, ea13, es13, ea13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
